// File: rtl/board_input_iface_pkg.sv
// Shared constants and helpers for the board switch/key input interface.
// Ports: none (package).
package board_input_iface_pkg;

  localparam int SW_W     = 10;
  localparam int BYTE_W   = 8;
  localparam int LED_W    = 9;
  localparam int MODE_BIT = 9;

  typedef enum logic {
    MODE_CTRL = 1'b0,
    MODE_DATA = 1'b1
  } mode_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int lane_w(input int lanes);
    return (clog2(lanes) < 1) ? 1 : clog2(lanes);
  endfunction

endpackage

// File: rtl/board_input_iface_if.sv
// Bundle of raw board inputs and captured outputs of board_input_iface.
// Ports: master drives keys/switches, slave (the block) drives the rest.
interface board_input_iface_if
  import board_input_iface_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 9
);

  localparam int LANE_W = lane_w(DATA_W / BYTE_W);

  logic              key_step_n;
  logic              key_lane_n;
  logic [SW_W-1:0]   sw;
  logic              step_pulse;
  logic [DATA_W-1:0] datapath_in;
  logic [CTRL_W-1:0] ctrl;
  logic [LANE_W-1:0] lane;
  logic [LED_W-1:0]  ledr;

  modport master (
    output key_step_n, key_lane_n, sw,
    input  step_pulse, datapath_in, ctrl, lane, ledr
  );

  modport slave (
    input  key_step_n, key_lane_n, sw,
    output step_pulse, datapath_in, ctrl, lane, ledr
  );

endinterface

// File: rtl/board_input_iface_key_debounce.sv
// Active-low key synchroniser + debouncer emitting one pulse per press.
// Ports: clk, rst_n, key_n (raw), press (registered 1-cycle pulse).
module key_debounce
  import board_input_iface_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             meta;
  logic             sync;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      meta  <= key_n;
      sync  <= meta;
      press <= 1'b0;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
        // pulse coincides with the first cycle stable reads 0
        press  <= ~sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/board_input_iface.sv
// Debounced key/switch capture into datapath byte lanes or control reg.
// Ports: clk, rst_n, bus (slave: keys, sw in; pulses, regs, leds out).
module board_input_iface
  import board_input_iface_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int CTRL_W       = 9,
  parameter int DEBOUNCE_CYC = 500000
) (
  input logic                clk,
  input logic                rst_n,
  board_input_iface_if.slave bus
);

  localparam int NUM_LANES = DATA_W / BYTE_W;
  localparam int LANE_W    = lane_w(NUM_LANES);

  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;
  logic              step_pulse;
  logic              lane_pulse;
  logic              data_mode;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [LANE_W-1:0] lane_q;
  logic [BYTE_W-1:0] lane_byte;
  logic [LED_W-1:0]  ledr;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_step (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(bus.key_step_n),
    .press(step_pulse)
  );

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_lane (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(bus.key_lane_n),
    .press(lane_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= bus.sw;
      sw_sync <= sw_meta;
    end
  end

  assign data_mode = (sw_sync[MODE_BIT] == MODE_DATA);

  // capture uses the pre-edge lane, so a same-cycle lane
  // press takes effect only for the next capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ctrl_q <= '0;
      lane_q <= '0;
    end else begin
      if (step_pulse) begin
        if (data_mode) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_q == LANE_W'(i)) begin
              data_q[i*BYTE_W +: BYTE_W] <= sw_sync[BYTE_W-1:0];
            end
          end
        end else begin
          ctrl_q <= sw_sync[CTRL_W-1:0];
        end
      end
      if (lane_pulse) begin
        if (lane_q == LANE_W'(NUM_LANES - 1)) begin
          lane_q <= '0;
        end else begin
          lane_q <= lane_q + LANE_W'(1);
        end
      end
    end
  end

  always_comb begin
    lane_byte = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        lane_byte = data_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    ledr = '0;
    if (data_mode) begin
      ledr[BYTE_W-1:0] = lane_byte;
    end else begin
      ledr[CTRL_W-1:0] = ctrl_q;
    end
  end

  assign bus.step_pulse  = step_pulse;
  assign bus.datapath_in = data_q;
  assign bus.ctrl        = ctrl_q;
  assign bus.lane        = lane_q;
  assign bus.ledr        = ledr;

endmodule
